// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, enable, modulus and wrap/saturate mode.
// Optional sticky compare-hit output when COUNTER_CMP_EN is defined.
module updown_counter_param #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] D,
    input  logic             u_d,
    input  logic             sat,
`ifdef COUNTER_CMP_EN
    input  logic [WIDTH-1:0] cmp_val,
    output logic             cmp_hit,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic             r_udf;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_ovf_nxt;
    logic             w_udf_nxt;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_ld_val;

    assign w_at_max  = (r_q == MAX_VAL);
    assign w_at_zero = (r_q == '0);
    assign w_ld_val  = (D > MAX_VAL) ? MAX_VAL : D;

    // Flags default low so they only pulse for the step that hit a bound.
    always_comb begin
        w_q_nxt   = r_q;
        w_ovf_nxt = 1'b0;
        w_udf_nxt = 1'b0;
        if (ld) begin
            w_q_nxt = w_ld_val;
        end else if (en) begin
            if (u_d) begin
                if (w_at_max) begin
                    w_ovf_nxt = 1'b1;
                    w_q_nxt   = sat ? MAX_VAL : '0;
                end else begin
                    w_q_nxt = r_q + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_udf_nxt = 1'b1;
                    w_q_nxt   = sat ? '0 : MAX_VAL;
                end else begin
                    w_q_nxt = r_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= RST_VAL;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_ovf <= w_ovf_nxt;
            r_udf <= w_udf_nxt;
        end
    end

`ifdef COUNTER_CMP_EN
    logic r_cmp_hit;

    // Sticky until a load or reset; load beats a same-edge match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_hit <= 1'b0;
        end else if (ld) begin
            r_cmp_hit <= 1'b0;
        end else if (r_q == cmp_val) begin
            r_cmp_hit <= 1'b1;
        end
    end

    assign cmp_hit = r_cmp_hit;
`endif

    assign Q   = r_q;
    assign ovf = r_ovf;
    assign udf = r_udf;
    assign tc  = u_d ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param (WIDTH=4, MAX_VAL=9): vector table, corner
// sequences and randomized stimulus against a behavioural model.
module tb_updown_counter_param;

    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       rst, en, ld, u_d, sat;
    logic [3:0] D;
    logic [3:0] Q;
    logic       tc, ovf, udf;
`ifdef COUNTER_CMP_EN
    logic [3:0] cmp_val;
    logic       cmp_hit;
`endif

    int n_vec = 0;
    int n_err = 0;

    int m_q, m_ovf, m_udf, m_hit, m_cmp;

    updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .RST_VAL(4'd0)) dut (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .D(D), .u_d(u_d), .sat(sat),
`ifdef COUNTER_CMP_EN
        .cmp_val(cmp_val), .cmp_hit(cmp_hit),
`endif
        .Q(Q), .tc(tc), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld, en, u_d, sat;
        logic [3:0] d;
        logic [3:0] q;
        logic       ovf, udf, tc;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_ovf = 0; m_udf = 0; m_hit = 0;
    endtask

    // Behavioural reference: one clock edge worth of the counting rules.
    task automatic model_edge(input logic r, input logic l, input logic e,
                              input logic ud, input logic s, input int d);
        int old_q;
        old_q = m_q;
        if (r) begin
            model_reset();
        end else if (l) begin
            m_q = (d > MAXV) ? MAXV : d;
            m_ovf = 0; m_udf = 0; m_hit = 0;
        end else begin
            m_ovf = 0; m_udf = 0;
            if (e && ud) begin
                if (old_q == MAXV) begin m_ovf = 1; m_q = s ? MAXV : 0; end
                else m_q = old_q + 1;
            end else if (e) begin
                if (old_q == 0) begin m_udf = 1; m_q = s ? 0 : MAXV; end
                else m_q = old_q - 1;
            end
            if (old_q == m_cmp) m_hit = 1;
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic e,
                       input logic ud, input logic s, input logic [3:0] d);
        rst = r; ld = l; en = e; u_d = ud; sat = s; D = d;
        @(posedge clk);
        model_edge(r, l, e, ud, s, int'(d));
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " Q"},   int'(Q),   m_q);
        chk({tag, " ovf"}, int'(ovf), m_ovf);
        chk({tag, " udf"}, int'(udf), m_udf);
        chk({tag, " tc"},  int'(tc),  u_d ? int'(m_q == MAXV) : int'(m_q == 0));
`ifdef COUNTER_CMP_EN
        chk({tag, " cmp_hit"}, int'(cmp_hit), m_hit);
`endif
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd5,  4'd5, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd14, 4'd9, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd8,  4'd8, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  4'd9, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd8, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  4'd3, 1'b0, 1'b0, 1'b0};

        m_cmp = 3;
`ifdef COUNTER_CMP_EN
        cmp_val = 4'd3;
`endif
        rst = 1'b1; ld = 1'b0; en = 1'b0; u_d = 1'b1; sat = 1'b0; D = '0;
        model_reset();
        #2;
        chk("reset Q", int'(Q), 0);
        chk("reset ovf", int'(ovf), 0);
        chk("reset udf", int'(udf), 0);
        @(posedge clk); #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        for (int i = 0; i < 18; i++) begin
            cyc(1'b0, tbl[i].ld, tbl[i].en, tbl[i].u_d, tbl[i].sat, tbl[i].d);
            chk($sformatf("vec%0d Q", i),   int'(Q),   int'(tbl[i].q));
            chk($sformatf("vec%0d ovf", i), int'(ovf), int'(tbl[i].ovf));
            chk($sformatf("vec%0d udf", i), int'(udf), int'(tbl[i].udf));
            chk($sformatf("vec%0d tc", i),  int'(tc),  int'(tbl[i].tc));
        end

        // Async reset mid-count at Q=6, and clearing a live ovf pulse.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6);
        en = 1'b1;
        #2 rst = 1'b1;
        #1 chk("async Q", int'(Q), 0);
        chk("async udf", int'(udf), 0);
        model_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        chk("sat ovf before rst", int'(ovf), 1);
        #2 rst = 1'b1;
        #1 chk("async ovf", int'(ovf), 0);
        chk("async Q2", int'(Q), 0);
        model_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk_model("resume");

        // Direction change at Q=9: tc follows u_d without a clock.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
        chk("tc up@9", int'(tc), 1);
        u_d = 1'b0;
        #1 chk("tc down@9", int'(tc), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("step after toggle", int'(Q), 8);

`ifdef COUNTER_CMP_EN
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            chk_model($sformatf("cmp up%0d", i));
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7);
        chk("cmp ld clear", int'(cmp_hit), 0);
`endif

        for (int i = 0; i < 800; i++) begin
            logic r, l, e, ud, s;
            logic [3:0] d;
            r  = ($urandom_range(0, 39) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            ud = 1'($urandom);
            s  = 1'($urandom);
            d  = 4'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                m_cmp = $urandom_range(0, MAXV);
`ifdef COUNTER_CMP_EN
                cmp_val = 4'(m_cmp);
`endif
            end
            cyc(r, l, e, ud, s, d);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
